// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants.
// Used by the hazard controller and the flush consumers.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       use1,
    input logic [4:0] rs2,
    input logic       use2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and stage enables back.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       ex_jump;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_we;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_mem_read, ex_branch_taken, ex_jump,
    output dmem_req, dmem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_flush, exmem_we
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_mem_read, ex_branch_taken, ex_jump,
    input  dmem_req, dmem_ready,
    output pc_we, ifid_we, ifid_flush, idex_flush, exmem_we
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, stick at max, clear wins
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: memory wait > redirect > load-use.
// Small FSM covers memory wait timeout and redirect flush.
import cpu_pkg::*;

module hazard_ctrl #(
  parameter int BR_FLUSH    = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);

  localparam int FC_W =
    (BR_FLUSH > 0) ? $clog2(BR_FLUSH + 1) : 1;
  localparam int WC_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX =
    WC_W'(MEM_TIMEOUT - 1);
  localparam logic [FC_W-1:0] FC_INIT =
    FC_W'(BR_FLUSH);

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  state_t          eff;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            tmo_d;
  logic            w, r, l;
  logic            pc_we, ifid_we, exmem_we;
  logic            ifid_flush, idex_flush;
  logic            clr;

  assign w = hz.dmem_req & ~hz.dmem_ready;
  assign r = hz.ex_branch_taken | hz.ex_jump;
  assign l = load_use(hz.ex_mem_read, hz.ex_rd,
                      hz.id_rs1, hz.id_use_rs1,
                      hz.id_rs2, hz.id_use_rs2);

  // MEMWAIT behaves as its return state once memory releases
  always_comb begin
    unique case (state_q)
      ST_MEMWAIT: eff = ret_q;
      ST_FLUSH:   eff = ST_FLUSH;
      default:    eff = ST_RUN;
    endcase
  end

  // next state, counters and stage enables
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    fcnt_d     = fcnt_q;
    wcnt_d     = wcnt_q;
    tmo_d      = mem_timeout;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    exmem_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (w) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      if (state_q == ST_MEMWAIT) begin
        if (wcnt_q == WC_MAX) begin
          tmo_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end else begin
        state_d = ST_MEMWAIT;
        ret_d   = eff;
        wcnt_d  = '0;
      end
    end else begin
      priority case (1'b1)
        (eff == ST_FLUSH): begin
          ifid_flush = 1'b1;
          if (fcnt_q <= FC_W'(1)) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end else begin
            state_d = ST_FLUSH;
            fcnt_d  = fcnt_q - FC_W'(1);
          end
        end
        r: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (BR_FLUSH > 0) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        l: begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          state_d    = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    if (state_q == ST_BAD) begin
      state_d = ST_RUN;
    end
  end

  // state register, flush/wait counts, sticky timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      fcnt_q      <= '0;
      wcnt_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      fcnt_q      <= fcnt_d;
      wcnt_q      <= wcnt_d;
      mem_timeout <= tmo_d;
    end
  end

  assign hz.pc_we      = pc_we;
  assign hz.ifid_we    = ifid_we;
  assign hz.exmem_we   = exmem_we;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign state_o       = state_q;
  assign clr           = ~rst_n;

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .clear (clr),
    .inc   (~pc_we),
    .cnt   (perf_stall)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .clear (clr),
    .inc   (ifid_flush),
    .cnt   (perf_flush)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// BR_FLUSH=1, MEM_TIMEOUT=4, 4-bit counters.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mem_timeout;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;
  int               n_cmp = 0;
  int               n_err = 0;

  hazard_ctrl_if hz();

  hazard_ctrl #(
    .BR_FLUSH    (1),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz.slave),
    .mem_timeout (mem_timeout),
    .state_o     (state_o),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz.id_rs1          = '0;
    hz.id_rs2          = '0;
    hz.id_use_rs1      = 1'b0;
    hz.id_use_rs2      = 1'b0;
    hz.ex_rd           = '0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_jump         = 1'b0;
    hz.dmem_req        = 1'b0;
    hz.dmem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = rd;
    hz.id_rs2      = rd;
    hz.id_use_rs2  = 1'b1;
  endtask

  task automatic chk_en(input string tag,
                        input logic [4:0] exp);
    chk(tag, {hz.pc_we, hz.ifid_we, hz.exmem_we,
              hz.ifid_flush, hz.idex_flush}, exp);
  endtask

  initial begin
    clr_in();
    // idle after reset; {pc,ifid,exmem,ifflush,idflush}
    do_reset();
    chk("rst_state", state_o, 0);
    chk("rst_tmo", mem_timeout, 0);
    chk_en("idle_en", 5'b11100);
    for (int i = 0; i < 10; i++) tick();
    chk("idle_stall", perf_stall, 0);
    chk("idle_flush", perf_flush, 0);
    chk_en("idle_en2", 5'b11100);

    // load-use on rs2
    set_lu(5'd5);
    #1 chk_en("lu_rs2", 5'b00101);
    tick();
    clr_in();
    #1 chk("lu_stall", perf_stall, 1);
    chk("lu_state", state_o, 0);
    chk_en("lu_after", 5'b11100);
    // x0 destination never stalls
    set_lu(5'd0);
    #1 chk_en("lu_x0", 5'b11100);
    tick();
    // rs1 match with use flag, then without
    clr_in();
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = 5'd7;
    hz.id_rs1      = 5'd7;
    hz.id_use_rs1  = 1'b1;
    #1 chk_en("lu_rs1", 5'b00101);
    hz.id_use_rs1 = 1'b0;
    #1 chk_en("lu_nouse", 5'b11100);
    hz.ex_mem_read = 1'b0;
    hz.id_use_rs1  = 1'b1;
    #1 chk_en("lu_noload", 5'b11100);
    tick();
    chk("lu_stall2", perf_stall, 1);

    // taken branch plus load-use: redirect wins
    do_reset();
    hz.ex_branch_taken = 1'b1;
    set_lu(5'd3);
    #1 chk_en("br_c0", 5'b11111);
    tick();
    // in FLUSH: new jump and load-use ignored
    clr_in();
    hz.ex_jump = 1'b1;
    set_lu(5'd3);
    #1 chk("br_c1_state", state_o, 2);
    chk_en("br_c1", 5'b11110);
    tick();
    clr_in();
    #1 chk("br_c2_state", state_o, 0);
    chk_en("br_c2", 5'b11100);
    chk("br_flush", perf_flush, 2);
    chk("br_stall", perf_stall, 0);

    // memory wait with branch and load-use: freeze only
    do_reset();
    hz.dmem_req        = 1'b1;
    hz.ex_branch_taken = 1'b1;
    set_lu(5'd9);
    #1 chk_en("mw_c0", 5'b00000);
    chk("mw_c0_state", state_o, 0);
    tick();
    #1 chk("mw_c1_state", state_o, 1);
    chk_en("mw_c1", 5'b00000);
    tick();
    chk("mw_c2_state", state_o, 1);
    tick();
    clr_in();
    hz.dmem_req   = 1'b1;
    hz.dmem_ready = 1'b1;
    #1 chk_en("mw_rel", 5'b11100);
    chk("mw_rel_state", state_o, 1);
    tick();
    clr_in();
    #1 chk("mw_end_state", state_o, 0);
    chk("mw_stall", perf_stall, 3);
    chk("mw_tmo", mem_timeout, 0);

    // wait during redirect flush keeps flushing afterwards
    do_reset();
    hz.ex_jump = 1'b1;
    tick();
    clr_in();
    hz.dmem_req = 1'b1;
    #1 chk("fw_state", state_o, 2);
    chk_en("fw_frz", 5'b00000);
    tick();
    chk("fw_mw", state_o, 1);
    hz.dmem_ready = 1'b1;
    #1 chk_en("fw_rel", 5'b11110);
    tick();
    clr_in();

    // timeout: ready never comes
    do_reset();
    hz.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("tmo_c4", mem_timeout, 0);
    tick();
    chk("tmo_c5", mem_timeout, 1);
    for (int i = 0; i < 12; i++) tick();
    chk("tmo_sat", perf_stall, 15);
    chk("tmo_hold", mem_timeout, 1);
    chk("tmo_state", state_o, 1);
    hz.dmem_req = 1'b0;
    tick();
    chk("tmo_sticky", mem_timeout, 1);
    chk("tmo_run", state_o, 0);

    // reset clears everything
    do_reset();
    #1 chk("rst2_tmo", mem_timeout, 0);
    chk("rst2_state", state_o, 0);
    chk("rst2_stall", perf_stall, 0);
    chk("rst2_flush", perf_flush, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
